// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: serial double-dabble left field, raw BCD
// right field, leading-zero blanking, overflow dashes, per-field blink and dp.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int LEFT_DIGITS  = 3,
  parameter int RIGHT_DIGITS = 2,
  parameter int BIN_W        = 10,
  parameter int SCAN_DIV     = 30,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BIN_W-1:0]          bin_in,
  input  logic                      bin_valid,
  output logic                      bin_ready,
  input  logic                      lz_blank,
  input  logic [4*RIGHT_DIGITS-1:0] right_bcd,
  input  logic                      right_en,
  input  logic                      blink_left,
  input  logic                      blink_right,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [NUM_DIGITS-1:0]     tub_sel,
  output logic [7:0]                tub_control1,
  output logic [7:0]                tub_control2
);

  localparam int ACC_W      = 4 * LEFT_DIGITS;
  localparam int CNT_W      = $clog2(BIN_W + 1);
  localparam int DIV_W      = $clog2(SCAN_DIV);
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int FRM_W      = $clog2(BLINK_FRAMES) + 1;
  localparam int RIGHT_BASE = NUM_DIGITS - RIGHT_DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LEFT_MAX = pow10(LEFT_DIGITS) - 64'd1;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_t;

  conv_state_t       state, state_next;
  logic [BIN_W-1:0]  shreg;
  logic [ACC_W-1:0]  acc, acc_adj;
  logic [CNT_W-1:0]  bit_cnt;
  logic              ovf_pend;
  logic [ACC_W-1:0]  disp_bcd;
  logic              disp_ovf;
  logic              accept;

  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  idx;
  logic [FRM_W-1:0]  frame_cnt;
  logic              blink_phase;

  logic [7:0]        digit_seg [NUM_DIGITS];
  logic              lz_seen;
  logic [3:0]        nib;

  assign accept = bin_valid & bin_ready;

  // ---------------- converter FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept) state_next = S_SHIFT;
      S_SHIFT: if (bit_cnt == CNT_W'(BIN_W - 1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Only the low LEFT_DIGITS nibbles are kept: carries in double-dabble move
  // strictly upward, so truncation never corrupts the retained digits.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < LEFT_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg     <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      ovf_pend  <= 1'b0;
      disp_bcd  <= '0;
      disp_ovf  <= 1'b0;
      bin_ready <= 1'b0;
    end else begin
      bin_ready <= (state_next == S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg    <= bin_in;
            acc      <= '0;
            bit_cnt  <= '0;
            ovf_pend <= (64'(bin_in) > LEFT_MAX);
          end
        end
        S_SHIFT: begin
          acc     <= {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        S_DONE: begin
          disp_bcd <= acc;
          disp_ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scan timing ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt     <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      if (idx == IDX_W'(NUM_DIGITS - 1)) begin
        idx <= '0;
        if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------- per-digit segment patterns ----------------
  always_comb begin
    lz_seen = 1'b0;
    nib     = 4'd0;
    for (int p = 0; p < NUM_DIGITS; p++) digit_seg[p] = 8'h00;

    for (int p = 0; p < LEFT_DIGITS; p++) begin
      nib     = disp_bcd[4*(LEFT_DIGITS-1-p) +: 4];
      lz_seen = lz_seen | (nib != 4'd0) | (p == LEFT_DIGITS - 1);
      if (blink_left && blink_phase) digit_seg[p] = 8'h00;
      else if (disp_ovf)             digit_seg[p] = 8'h40;
      else if (lz_blank && !lz_seen) digit_seg[p] = 8'h00;
      else                           digit_seg[p] = seg_decode(nib);
    end

    for (int r = 0; r < RIGHT_DIGITS; r++) begin
      nib = right_bcd[4*(RIGHT_DIGITS-1-r) +: 4];
      if (right_en && !(blink_right && blink_phase))
        digit_seg[RIGHT_BASE + r] = seg_decode(nib);
    end

    // Decimal point survives every kind of blanking.
    for (int p = 0; p < NUM_DIGITS; p++)
      digit_seg[p][7] = digit_seg[p][7] | dp_mask[p];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tub_sel      <= '0;
      tub_control1 <= 8'h00;
      tub_control2 <= 8'h00;
    end else begin
      tub_sel <= NUM_DIGITS'(1) << idx;
      if (idx < IDX_W'(NUM_DIGITS / 2)) begin
        tub_control1 <= digit_seg[idx];
        tub_control2 <= 8'h00;
      end else begin
        tub_control1 <= 8'h00;
        tub_control2 <= digit_seg[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench: a cycle-level behavioural model predicts every output
// each cycle; directed literal expectations pin both the DUT and the model.
module tb_seg_scan_display;

  localparam int ND = 8;
  localparam int LD = 3;
  localparam int RD = 2;
  localparam int BW = 10;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] bin_in = '0;
  logic          bin_valid = 1'b0;
  logic          bin_ready;
  logic          lz_blank = 1'b0;
  logic [4*RD-1:0] right_bcd = '0;
  logic          right_en = 1'b0;
  logic          blink_left = 1'b0;
  logic          blink_right = 1'b0;
  logic [ND-1:0] dp_mask = '0;
  logic [ND-1:0] tub_sel;
  logic [7:0]    tub_control1;
  logic [7:0]    tub_control2;

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS(ND), .LEFT_DIGITS(LD), .RIGHT_DIGITS(RD),
    .BIN_W(BW), .SCAN_DIV(SD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset),
    .bin_in(bin_in), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .lz_blank(lz_blank), .right_bcd(right_bcd), .right_en(right_en),
    .blink_left(blink_left), .blink_right(blink_right), .dp_mask(dp_mask),
    .tub_sel(tub_sel), .tub_control1(tub_control1), .tub_control2(tub_control2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // ---------------- behavioural model ----------------
  bit         m_valid = 1'b0;
  int         k;        // posedges since reset release
  int         m_val, m_pend, m_done;
  bit         m_ovf, m_busy, m_ready;
  logic [ND-1:0] e_sel;
  logic [7:0] e_c1, e_c2;

  function automatic logic [7:0] exp_seg(input int p, input int phase);
    logic [7:0] s;
    int pw, nb, r;
    s = 8'h00;
    if (p < LD) begin
      if (!(blink_left && phase == 1)) begin
        if (m_ovf) s = 8'h40;
        else begin
          pw = 10 ** (LD - 1 - p);
          if (!(lz_blank && p < LD - 1 && m_val < pw)) s = seg_tab[(m_val / pw) % 10];
        end
      end
    end else if (p >= ND - RD) begin
      r  = p - (ND - RD);
      nb = int'((right_bcd >> (4 * (RD - 1 - r))) & 8'hF);
      if (right_en && !(blink_right && phase == 1) && nb <= 9) s = seg_tab[nb];
    end
    if (dp_mask[p]) s[7] = 1'b1;
    return s;
  endfunction

  function automatic int cur_phase();
    return ((k - 1) / (SD * ND * BF)) % 2;
  endfunction

  always @(posedge clk) begin
    int digit;
    logic [7:0] s;
    if (!reset) begin
      m_valid = 1'b1;
      k = 0; m_val = 0; m_ovf = 1'b0; m_busy = 1'b0; m_ready = 1'b0;
      e_sel = '0; e_c1 = 8'h00; e_c2 = 8'h00;
    end else if (m_valid) begin
      k++;
      digit = ((k - 1) / SD) % ND;
      s     = exp_seg(digit, cur_phase());
      e_sel = ND'(1) << digit;
      e_c1  = (digit < ND / 2) ? s : 8'h00;
      e_c2  = (digit < ND / 2) ? 8'h00 : s;
      if (m_busy) begin
        if (k == m_done) begin
          m_val = m_pend; m_ovf = (m_pend > 10 ** LD - 1);
          m_busy = 1'b0; m_ready = 1'b1;
        end
      end else if (m_ready && bin_valid) begin
        m_pend = int'(bin_in); m_done = k + BW + 1;
        m_busy = 1'b1; m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("tub_sel", 32'(tub_sel), 32'(e_sel));
      check("tub_control1", 32'(tub_control1), 32'(e_c1));
      check("tub_control2", 32'(tub_control2), 32'(e_c2));
      check("bin_ready", 32'(bin_ready), 32'(m_ready));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_digit(input int p, output logic [7:0] seg);
    bit found;
    found = 1'b0;
    seg = 8'h00;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (tub_sel == (ND'(1) << p)) begin
        found = 1'b1;
        seg = (p < ND / 2) ? tub_control1 : tub_control2;
      end
    end
    check("wait_digit_found", 32'(found), 32'd1);
  endtask

  task automatic pin(input string name, input int p, input logic [7:0] exp);
    logic [7:0] s;
    wait_digit(p, s);
    check(name, 32'(s), 32'(exp));
    check({name, "_model"}, 32'(exp_seg(p, cur_phase())), 32'(exp));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bin_ready && n < 200) begin step(); n++; end
    check("ready_wait", 32'(bin_ready), 32'd1);
  endtask

  task automatic convert(input int v, output int low);
    wait_ready();
    bin_in = BW'(v); bin_valid = 1'b1;
    step();
    bin_valid = 1'b0;
    low = 0;
    while (!bin_ready && low < 100) begin low++; step(); end
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    repeat (3) step();
    check("rst_sel", 32'(tub_sel), 32'd0);
    check("rst_c1", 32'(tub_control1), 32'd0);
    check("rst_c2", 32'(tub_control2), 32'd0);
    check("rst_ready", 32'(bin_ready), 32'd0);

    // Scan order: each digit held SD cycles, only its own bank driven.
    reset = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      step();
      check("scan_sel", 32'(tub_sel), 32'(ND'(1) << (((n - 1) / SD) % ND)));
      check("scan_other_bank", 32'((((n - 1) / SD) % ND) < ND / 2 ? tub_control2 : tub_control1), 32'd0);
      if (n == 1) check("first_ready", 32'(bin_ready), 32'd1);
    end

    convert(420, low);
    check("ready_low_cycles", 32'(low), 32'd11);
    pin("v420_d0", 0, 8'h66);
    pin("v420_d1", 1, 8'h5B);
    pin("v420_d2", 2, 8'h3F);

    lz_blank = 1'b1;
    convert(7, low);
    pin("lz7_d0", 0, 8'h00);
    pin("lz7_d1", 1, 8'h00);
    pin("lz7_d2", 2, 8'h07);
    convert(0, low);
    pin("lz0_d0", 0, 8'h00);
    pin("lz0_d2", 2, 8'h3F);
    convert(50, low);
    pin("lz50_d0", 0, 8'h00);
    pin("lz50_d1", 1, 8'h6D);
    pin("lz50_d2", 2, 8'h3F);
    lz_blank = 1'b0;

    convert(1000, low);
    for (int p = 0; p < LD; p++) pin("ovf_dash", p, 8'h40);
    convert(999, low);
    for (int p = 0; p < LD; p++) pin("v999", p, 8'h6F);

    right_en = 1'b1; right_bcd = 8'h59;
    pin("r59_d6", 6, 8'h6D);
    pin("r59_d7", 7, 8'h6F);
    right_bcd = 8'h5A;
    pin("r5A_d7", 7, 8'h00);
    right_en = 1'b0;
    pin("roff_d6", 6, 8'h00);
    pin("roff_d7", 7, 8'h00);
    dp_mask = 8'h40;
    pin("dp_d6", 6, 8'h80);
    dp_mask = 8'h00;

    // A load request during the shift phase is dropped.
    wait_ready();
    bin_in = BW'(123); bin_valid = 1'b1;
    step();
    bin_valid = 1'b0;
    repeat (3) step();
    bin_in = BW'(456); bin_valid = 1'b1;
    step();
    bin_valid = 1'b0;
    wait_ready();
    step();
    pin("ign_d0", 0, 8'h06);
    pin("ign_d1", 1, 8'h5B);
    pin("ign_d2", 2, 8'h4F);

    // Reset in the middle of a conversion.
    bin_in = BW'(777); bin_valid = 1'b1;
    step();
    bin_valid = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    step();
    check("midrst_sel", 32'(tub_sel), 32'd0);
    check("midrst_c1", 32'(tub_control1), 32'd0);
    check("midrst_ready", 32'(bin_ready), 32'd0);
    reset = 1'b1;
    step();
    check("midrst_release_ready", 32'(bin_ready), 32'd1);
    pin("midrst_d0", 0, 8'h3F);
    pin("midrst_d2", 2, 8'h3F);

    // Blink: right field alternates every BF frames, left untouched.
    reset = 1'b0;
    right_en = 1'b1; right_bcd = 8'h59; blink_right = 1'b1;
    step();
    reset = 1'b1;
    pin("blink_on_d6", 6, 8'h6D);
    repeat (40) step();
    pin("blink_off_d6", 6, 8'h00);
    pin("blink_left_d2", 2, 8'h3F);
    repeat (40) step();
    pin("blink_on2_d6", 6, 8'h6D);
    blink_right = 1'b0;

    // Randomised traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      bin_valid = ($urandom_range(0, 5) == 0);
      bin_in    = BW'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) lz_blank    = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) right_en    = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) right_bcd   = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blink_left  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) blink_right = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) dp_mask     = 8'($urandom);
      reset = ($urandom_range(0, 599) != 0);
      step();
    end
    reset = 1'b1;
    bin_valid = 1'b0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
